mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 mem_read_op  in  3  load op from control: LB=000, LH=001, LW=010, LBU=100, LHU=101, LNONE=111.
REQ-004 mem_write_op  in  2  store op from control: SB=00, SH=01, SW=10, SNONE=11.
REQ-005 addr  in  32  byte address from ALU result.
REQ-006 wdata  in  32  store data (rs2), right-aligned.
REQ-007 rdata  out  32  aligned, sign/zero-extended load result.
REQ-008 busy  out  1  stall to control; step must not advance while high.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 err  out  1  one-cycle fault pulse (misaligned or timeout), coincident with done.
REQ-011 bus_req  out  1  bus request, held until bus_ack.
REQ-012 bus_we  out  1  1=write, 0=read.
REQ-013 bus_addr  out  30  word address (addr[31:2]).
REQ-014 bus_be  out  4  byte enables, bit n = byte lane n (little-endian).
REQ-015 bus_wdata  out  32  lane-replicated store data.
REQ-016 bus_rdata  in  32  read word, valid when bus_ack=1.
REQ-017 bus_ack  in  1  transfer complete for current request.
REQ-018 Parameter TIMEOUT, default 255: max REQ-state cycles without bus_ack.

Function
REQ-019 FSM states IDLE, REQ, DONE; op "present" = read_op!=LNONE or write_op!=SNONE.
REQ-020 IDLE, op present, aligned: register addr/lanes/data/op, go REQ next cycle; bus_req=1 from first REQ cycle.
REQ-021 Write op takes precedence when both ops present; read ignored.
REQ-022 Misaligned (H at addr[0]=1; W at addr[1:0]!=0; any B is aligned): no bus_req, go DONE with err=1, rdata=0.
REQ-023 busy = (IDLE and op present) or REQ; busy=0 in DONE.
REQ-024 REQ: bus_req, bus_we, bus_addr, bus_be, bus_wdata stable until bus_ack; bus_ack in first REQ cycle allowed.
REQ-025 REQ and bus_ack: capture load result into rdata (writes: rdata=0), go DONE.
REQ-026 Wait counter (8 bit) clears on REQ entry, increments each REQ cycle without bus_ack; at count=TIMEOUT drop bus_req, go DONE with err=1, rdata=0.
REQ-027 DONE: done=1 for exactly one cycle, always return to IDLE; ops present in DONE ignored (requester changes op next cycle).
REQ-028 rdata holds value until next DONE.
REQ-029 Store lanes: SB be=0001<<addr[1:0], wdata[7:0] replicated x4; SH be=0011<<{addr[1],0}, wdata[15:0] x2; SW be=1111, wdata as-is.
REQ-030 Loads: bus_be as for equal-size store; byte/half selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-031 Minimum latency aligned access: accept cycle + 1 REQ cycle + DONE = done 2 cycles after acceptance edge.
REQ-032 Inputs mem_read_op, mem_write_op, addr, wdata ignored outside IDLE.

Reset
REQ-033 reset_n=0 asynchronously forces IDLE, counter=0, rdata=0, busy/done/err/bus_req/bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0.
REQ-034 Reset mid-REQ drops bus_req immediately; no done pulse; pending transfer abandoned.

Verification
REQ-035 LB addr=0x103, bus_rdata=0x80FF_1234, ack first REQ cycle -> bus_be=1000, rdata=0xFFFFFF80, done 2 cycles after accept, err=0.
REQ-036 SH addr=0x202, wdata=0x0000ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x80.
REQ-037 LW addr=0x001 -> no bus_req, done=err=1 next cycle, rdata=0.
REQ-038 LHU addr=0x000, bus_ack withheld 3 cycles, bus_rdata=0x0000F00F -> bus_req held 4 cycles, rdata=0x0000F00F, busy high until DONE.
REQ-039 LW with bus_ack never asserted, TIMEOUT=255 -> bus_req drops after 255 REQ cycles, done=err=1, rdata=0.
REQ-040 reset_n pulsed low during REQ -> bus_req=0 and busy=0 immediately, no done; next LW completes normally.

Source files
------------

// File: rtl/mem_access_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_if : word-wide request/ack memory bus                    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface mem_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access : load/store unit bridging a CPU step to a req/ack bus   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  mem_read_op,
  input  logic [1:0]  mem_write_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  mem_access_if.master bus
);

  localparam logic [2:0] C_LNONE = 3'b111;
  localparam logic [1:0] C_SNONE = 2'b11;
  localparam logic [1:0] C_SZ_B  = 2'd0;
  localparam logic [1:0] C_SZ_H  = 2'd1;
  localparam logic [1:0] C_SZ_W  = 2'd2;
  localparam logic [8:0] C_TO    = 9'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [29:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;
  logic [1:0]  ld_size_q;
  logic        ld_signed_q;
  logic [1:0]  ld_off_q;

  logic        wr_present_d;
  logic        rd_present_d;
  logic        op_present_d;
  logic [1:0]  size_d;
  logic        misalign_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted_d;
  logic [31:0] ld_data_d;
  logic [8:0]  cnt_inc_d;
  logic        timeout_hit_d;

  assign wr_present_d = (mem_write_op != C_SNONE);
  assign rd_present_d = (mem_read_op != C_LNONE);
  assign op_present_d = wr_present_d | rd_present_d;

  // A store wins over a simultaneous load, so size comes from the store op first.
  always_comb begin
    size_d = C_SZ_W;
    if (wr_present_d) begin
      case (mem_write_op)
        2'b00:   size_d = C_SZ_B;
        2'b01:   size_d = C_SZ_H;
        default: size_d = C_SZ_W;
      endcase
    end else begin
      case (mem_read_op[1:0])
        2'b00:   size_d = C_SZ_B;
        2'b01:   size_d = C_SZ_H;
        default: size_d = C_SZ_W;
      endcase
    end
  end

  always_comb begin
    misalign_d = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = wdata;
    case (size_d)
      C_SZ_B: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      C_SZ_H: begin
        misalign_d = addr[0];
        be_d       = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d    = {2{wdata[15:0]}};
      end
      default: begin
        misalign_d = |addr[1:0];
      end
    endcase
  end

  always_comb begin
    shifted_d = bus.bus_rdata >> {ld_off_q, 3'b000};
    ld_data_d = bus.bus_rdata;
    case (ld_size_q)
      C_SZ_B:  ld_data_d = {{24{ld_signed_q & shifted_d[7]}}, shifted_d[7:0]};
      C_SZ_H:  ld_data_d = {{16{ld_signed_q & shifted_d[15]}}, shifted_d[15:0]};
      default: ld_data_d = bus.bus_rdata;
    endcase
  end

  // Timeout fires on the cycle the no-ack count reaches the limit.
  assign cnt_inc_d     = {1'b0, cnt_q} + 9'd1;
  assign timeout_hit_d = (cnt_inc_d >= C_TO);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 30'd0;
      bus_be_q    <= 4'd0;
      bus_wdata_q <= 32'd0;
      ld_size_q   <= C_SZ_W;
      ld_signed_q <= 1'b0;
      ld_off_q    <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          err_q <= 1'b0;
          if (op_present_d) begin
            if (misalign_d) begin
              state_q <= S_DONE;
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
            end else begin
              state_q     <= S_REQ;
              cnt_q       <= 8'd0;
              bus_req_q   <= 1'b1;
              bus_we_q    <= wr_present_d;
              bus_addr_q  <= addr[31:2];
              bus_be_q    <= be_d;
              bus_wdata_q <= wdata_d;
              ld_size_q   <= size_d;
              ld_signed_q <= ~mem_read_op[2];
              ld_off_q    <= addr[1:0];
            end
          end
        end
        S_REQ: begin
          if (bus.bus_ack) begin
            state_q   <= S_DONE;
            bus_req_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= bus_we_q ? 32'd0 : ld_data_d;
          end else if (timeout_hit_d) begin
            state_q   <= S_DONE;
            bus_req_q <= 1'b0;
            err_q     <= 1'b1;
            rdata_q   <= 32'd0;
          end else begin
            cnt_q <= cnt_inc_d[7:0];
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // busy is combinational in IDLE so a new op stalls the step in its issue cycle.
  assign busy  = reset_n & ((state_q == S_REQ) | ((state_q == S_IDLE) & op_present_d));
  assign done  = (state_q == S_DONE);
  assign err   = err_q;
  assign rdata = rdata_q;

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_access : directed scoreboard bench for mem_access            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_mem_access;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101, LNONE = 3'b111;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SNONE = 2'b11;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  mem_read_op = LNONE;
  logic [1:0]  mem_write_op = SNONE;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb_q[$];

  mem_access_if bus_if ();

  mem_access #(.TIMEOUT(255)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_read_op  (mem_read_op),
    .mem_write_op (mem_write_op),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_misaligned(input logic [2:0] rop, input logic [1:0] wop, input logic [31:0] a);
    if (wop != SNONE) return (wop == SH && a[0]) || (wop == SW && a[1:0] != 2'b00);
    return ((rop == LH || rop == LHU) && a[0]) || (rop == LW && a[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] rop, input logic [1:0] wop, input logic [31:0] a);
    logic [1:0] sz;
    sz = (wop != SNONE) ? wop : ((rop == LB || rop == LBU) ? 2'd0 : (rop == LH || rop == LHU) ? 2'd1 : 2'd2);
    case (sz)
      2'd0:    return (a[1:0] == 2'd0) ? 4'b0001 : (a[1:0] == 2'd1) ? 4'b0010 : (a[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] wop, input logic [31:0] d);
    case (wop)
      SB:      return {d[7:0], d[7:0], d[7:0], d[7:0]};
      SH:      return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] rop, input logic [31:0] a, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a[1:0] +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (rop)
      LB:      return 32'($signed(b));
      LBU:     return {24'd0, b};
      LH:      return 32'($signed(h));
      LHU:     return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Issue one op, act as the bus slave (ack after ack_wait no-ack REQ cycles,
  // ack_wait < 0 = never), and compare the completion against the scoreboard.
  task automatic do_op(input string tag, input logic [2:0] rop, input logic [1:0] wop,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                       input int ack_wait);
    exp_t e, got;
    logic mis;
    int   req_cycles, done_cyc, exp_req;
    logic done_seen;
    mis = is_misaligned(rop, wop, a);
    e.err   = mis || (ack_wait < 0);
    e.rdata = (e.err || wop != SNONE) ? 32'd0 : model_load(rop, a, rword);
    sb_q.push_back(e);
    exp_req = mis ? 0 : (ack_wait < 0 ? 255 : ack_wait + 1);

    @(negedge clk);
    mem_read_op = rop; mem_write_op = wop; addr = a; wdata = wd;
    #1 chk({tag, "_busy_issue"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    mem_read_op = 3'($urandom); mem_write_op = 2'($urandom); addr = $urandom; wdata = $urandom;

    req_cycles = 0; done_cyc = -1; done_seen = 1'b0;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        got.rdata = rdata;
        got.err   = err;
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        chk({tag, "_req_done"}, 32'(bus_if.bus_req), 32'd0);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk({tag, "_rdata"}, got.rdata, e.rdata);
          chk({tag, "_err"}, 32'(got.err), 32'(e.err));
        end else begin
          chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end
        mem_read_op = LNONE; mem_write_op = SNONE;
        bus_if.bus_ack = 1'b0;
      end else begin
        chk({tag, "_busy_req"}, 32'(busy), 32'd1);
        if (bus_if.bus_req) begin
          req_cycles++;
          chk({tag, "_we"}, 32'(bus_if.bus_we), 32'(wop != SNONE));
          chk({tag, "_be"}, 32'(bus_if.bus_be), 32'(model_be(rop, wop, a)));
          chk({tag, "_addr"}, 32'(bus_if.bus_addr), 32'(a[31:2]));
          if (wop != SNONE) chk({tag, "_wdata"}, bus_if.bus_wdata, model_wdata(wop, wd));
          bus_if.bus_ack   = (ack_wait >= 0) && (req_cycles - 1 == ack_wait);
          bus_if.bus_rdata = bus_if.bus_ack ? rword : $urandom;
        end else begin
          bus_if.bus_ack = 1'b0;
        end
      end
    end
    bus_if.bus_ack = 1'b0;
    if (!done_seen) begin
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
      mem_read_op = LNONE; mem_write_op = SNONE;
    end
    chk({tag, "_req_cycles"}, 32'(req_cycles), 32'(exp_req));
    chk({tag, "_latency"}, 32'(done_cyc), 32'(mis ? 0 : exp_req));
  endtask

  initial begin
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'd0;

    #2;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_we", 32'(bus_if.bus_we), 32'd0);
    chk("rst_be", 32'(bus_if.bus_be), 32'd0);
    chk("rst_addr", 32'(bus_if.bus_addr), 32'd0);
    chk("rst_wdata", bus_if.bus_wdata, 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    do_op("lb103", LB, SNONE, 32'h103, 32'h0, 32'h80FF_1234, 0);
    chk("lb103_const", rdata, 32'hFFFF_FF80);
    repeat (3) @(negedge clk);
    chk("rdata_hold", rdata, 32'hFFFF_FF80);

    do_op("sh202", LNONE, SH, 32'h202, 32'h0000_ABCD, 32'h0, 0);
    do_op("lw001", LW, SNONE, 32'h001, 32'h0, 32'hDEAD_BEEF, 0);
    chk("lw001_const", rdata, 32'd0);
    do_op("lhu000", LHU, SNONE, 32'h000, 32'h0, 32'h0000_F00F, 3);
    chk("lhu000_const", rdata, 32'h0000_F00F);
    do_op("lbu", LBU, SNONE, 32'h3A1, 32'h0, 32'h1234_C6AB, 1);
    do_op("lh_hi", LH, SNONE, 32'h3A2, 32'h0, 32'h9ABC_0001, 0);
    do_op("lh_lo", LH, SNONE, 32'h3A4, 32'h0, 32'h0001_7FFE, 2);
    do_op("sb", LNONE, SB, 32'h401, 32'h1234_565A, 32'h0, 0);
    do_op("sw", LNONE, SW, 32'h404, 32'hCAFE_F00D, 32'h0, 1);
    do_op("wr_wins", LW, SW, 32'h408, 32'h0BAD_CAFE, 32'h1111_1111, 0);
    do_op("sh_mis", LNONE, SH, 32'h203, 32'h1, 32'h0, 0);
    do_op("sb_ok", LNONE, SB, 32'h203, 32'hEE, 32'h0, 0);
    do_op("lw_to", LW, SNONE, 32'h500, 32'h0, 32'h5555_5555, -1);

    // Reset pulse while a read sits in REQ.
    @(negedge clk);
    mem_read_op = LW; addr = 32'h40;
    @(posedge clk); #1;
    mem_read_op = LNONE;
    @(negedge clk);
    chk("mid_req_up", 32'(bus_if.bus_req), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus_if.bus_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_nodone", 32'(done), 32'd0);
    end
    do_op("lw_after_rst", LW, SNONE, 32'h44, 32'h0, 32'h0123_4567, 1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire
